// File: rtl/push_top_assembler.sv
// Packs a framed byte stream into REC_BYTES-byte records, queues them in a small
// circular holding buffer and offers the head record to the FIFO manager.
module push_top_assembler #(
    parameter int REC_BYTES  = 6,
    parameter int HOLD_DEPTH = 2,
    parameter int CNT_W      = 16,
    localparam int RW        = 8 * REC_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             byte_start,
    output logic             push_wait,
    output logic             push_to_fifo,
    output logic [RW-1:0]    push_record,
    input  logic             fifo_full,
    input  logic             err_clr,
    output logic             frame_err,
    output logic [CNT_W-1:0] rec_count
);

    localparam int IDX_W = $clog2(REC_BYTES);
    localparam int PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int HC_W  = $clog2(HOLD_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);
    localparam logic [HC_W-1:0]  FULL_CNT = HC_W'(HOLD_DEPTH);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        ASSEMBLE = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   byte_idx_r, byte_idx_s;
    logic [RW-1:0]      asm_r, asm_s;
    logic [RW-1:0]      hold_mem_r [HOLD_DEPTH];
    logic [PTR_W-1:0]   head_r, tail_r, head_s, tail_s;
    logic [HC_W-1:0]    hold_cnt_r, hold_cnt_s;
    logic               push_wait_r, push_to_fifo_r, frame_err_r;
    logic [RW-1:0]      push_record_r, head_data_s;
    logic [CNT_W-1:0]   rec_count_r;
    logic               take_s, acc_s, wr_s, err_set_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(HOLD_DEPTH - 1)) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    assign take_s = byte_valid && !push_wait_r;
    assign acc_s  = push_to_fifo_r && !fifo_full;

    // Framing FSM: byte placement, record completion and framing-error detection
    always_comb begin
        state_s    = state_r;
        byte_idx_s = byte_idx_r;
        asm_s      = asm_r;
        wr_s       = 1'b0;
        err_set_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (take_s && byte_start) begin
                    asm_s      = {byte_in, {(RW-8){1'b0}}};
                    byte_idx_s = IDX_W'(1);
                    state_s    = ASSEMBLE;
                end else if (take_s) begin
                    err_set_s = 1'b1;
                end else begin
                    err_set_s = 1'b0;
                end
            end
            ASSEMBLE: begin
                if (take_s && byte_start) begin
                    // A fresh start abandons the partial record and begins anew
                    err_set_s  = 1'b1;
                    asm_s      = {byte_in, {(RW-8){1'b0}}};
                    byte_idx_s = IDX_W'(1);
                end else if (take_s) begin
                    for (int k = 0; k < REC_BYTES; k++) begin
                        asm_s[RW-1-8*k -: 8] = (byte_idx_r == IDX_W'(k)) ? byte_in
                                                                          : asm_r[RW-1-8*k -: 8];
                    end
                    if (byte_idx_r == LAST_IDX) begin
                        wr_s       = 1'b1;
                        byte_idx_s = {IDX_W{1'b0}};
                        state_s    = IDLE;
                    end else begin
                        byte_idx_s = byte_idx_r + IDX_W'(1);
                    end
                end else begin
                    err_set_s = 1'b0;
                end
            end
            default: begin
                state_s    = IDLE;
                byte_idx_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // Holding-queue pointer/occupancy update and next head record
    always_comb begin
        head_s     = acc_s ? ptr_inc(head_r) : head_r;
        tail_s     = wr_s ? ptr_inc(tail_r) : tail_r;
        hold_cnt_s = hold_cnt_r;
        case ({wr_s, acc_s})
            2'b10:   hold_cnt_s = hold_cnt_r + HC_W'(1);
            2'b01:   hold_cnt_s = hold_cnt_r - HC_W'(1);
            default: hold_cnt_s = hold_cnt_r;
        endcase
        // The record being written this edge becomes head only when it is the sole entry
        if (wr_s && (tail_r == head_s)) begin
            head_data_s = asm_s;
        end else begin
            head_data_s = hold_mem_r[head_s];
        end
    end

    // State, assembly, queue and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            byte_idx_r     <= {IDX_W{1'b0}};
            asm_r          <= {RW{1'b0}};
            head_r         <= {PTR_W{1'b0}};
            tail_r         <= {PTR_W{1'b0}};
            hold_cnt_r     <= {HC_W{1'b0}};
            push_wait_r    <= 1'b0;
            push_to_fifo_r <= 1'b0;
            push_record_r  <= {RW{1'b0}};
            frame_err_r    <= 1'b0;
            rec_count_r    <= {CNT_W{1'b0}};
            for (int i = 0; i < HOLD_DEPTH; i++) begin
                hold_mem_r[i] <= {RW{1'b0}};
            end
        end else begin
            state_r        <= state_s;
            byte_idx_r     <= byte_idx_s;
            asm_r          <= asm_s;
            head_r         <= head_s;
            tail_r         <= tail_s;
            hold_cnt_r     <= hold_cnt_s;
            push_to_fifo_r <= (hold_cnt_s != {HC_W{1'b0}});
            push_record_r  <= head_data_s;
            push_wait_r    <= (state_s == ASSEMBLE) && (byte_idx_s == LAST_IDX)
                              && (hold_cnt_s == FULL_CNT);
            if (wr_s) begin
                hold_mem_r[tail_r] <= asm_s;
            end
            if (err_set_s) begin
                frame_err_r <= 1'b1;
            end else if (err_clr) begin
                frame_err_r <= 1'b0;
            end
            if (acc_s) begin
                rec_count_r <= rec_count_r + CNT_W'(1);
            end
        end
    end

    assign push_wait    = push_wait_r;
    assign push_to_fifo = push_to_fifo_r;
    assign push_record  = push_record_r;
    assign frame_err    = frame_err_r;
    assign rec_count    = rec_count_r;

endmodule
